// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the boot loader and the core.
//   ld_state_t : boot-loader byte-stream state
//   MACH_W     : machine-code word width (9 bits)
package cpu_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    INS_LO,
    INS_HI,
    CHK,
    DONE,
    ERR
  } ld_state_t;

  localparam int MACH_W = 9;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream boot loader. Receives a length-prefixed, checksummed image of
// 9-bit machine-code words over a valid/ready byte link and writes it into the
// instruction RAM. The core is held in reset (core_hold=1) until the image has
// loaded and its checksum matches.
//
// Stream: N[7:0], N[15:8], then N pairs {code[7:0]}, {7'b0, code[8]},
// then one byte equal to the XOR of all 2N word bytes.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   host byte valid
//   in_data    in   host byte
//   in_ready   out  loader accepts a byte this cycle
//   wr_en      out  instruction-RAM write strobe (1 cycle per word)
//   wr_addr    out  instruction-RAM write address
//   wr_data    out  instruction-RAM write data
//   core_hold  out  1 = hold the core PC in reset
//   load_done  out  image loaded and checksum good (sticky)
//   load_err   out  overflow, bad high byte or bad checksum (sticky)
//   word_cnt   out  number of words written so far
module prog_loader
  import cpu_pkg::*;
#(
  parameter int D = 10,
  parameter int W = MACH_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [D:0]   word_cnt
);

  // Largest legal word count is exactly 2**D, compared in 17 bits.
  localparam logic [16:0] CAP = 17'd1 << D;

  ld_state_t      state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [7:0]     chk_q, chk_d;
  logic [7:0]     lo_q, lo_d;
  logic           rdy_q, rdy_d;
  logic           wr_en_q, wr_en_d;
  logic [D-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;
  logic [D:0]     cnt_q, cnt_d;

  logic           accept;
  logic [16:0]    n_full;
  logic [16:0]    cnt_next17;

  assign accept     = in_valid && rdy_q;
  assign n_full     = {1'b0, in_data, len_q[7:0]};
  assign cnt_next17 = 17'(cnt_q) + 17'd1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    chk_d     = chk_q;
    lo_d      = lo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          if (n_full > CAP)       state_d = ERR;
          else if (n_full == '0)  state_d = CHK;
          else                    state_d = INS_LO;
        end
      end
      INS_LO: begin
        if (accept) begin
          lo_d    = in_data;
          chk_d   = chk_q ^ in_data;
          state_d = INS_HI;
        end
      end
      INS_HI: begin
        if (accept) begin
          if (in_data[7:1] != 7'd0) begin
            state_d = ERR;
          end else begin
            chk_d     = chk_q ^ in_data;
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[D-1:0];
            wr_data_d = {in_data[0], lo_q};
            cnt_d     = cnt_q + (D+1)'(1);
            state_d   = (cnt_next17 == {1'b0, len_q}) ? CHK : INS_LO;
          end
        end
      end
      CHK: begin
        if (accept) state_d = (in_data == chk_q) ? DONE : ERR;
      end
      DONE, ERR: ;
      default: state_d = ERR;
    endcase

    // Ready is registered: it drops for the write-pulse cycle so the next
    // lo byte waits one cycle, and stays low in the terminal states.
    rdy_d = !wr_en_d && (state_d != DONE) && (state_d != ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LEN_LO;
      len_q     <= '0;
      chk_q     <= '0;
      lo_q      <= '0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      lo_q      <= lo_d;
      rdy_q     <= rdy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = rdy_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign word_cnt  = cnt_q;
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);
  assign core_hold = (state_q != DONE);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  logic       core_hold;
  logic       load_done;
  logic       load_err;
  logic [10:0] word_cnt;

  always #5 clk = ~clk;

  prog_loader #(.D(10), .W(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  typedef struct {
    logic [9:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total   = 0;
  int  passed  = 0;
  int  gap_pct = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe is matched against the queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
      check("in_ready_in_wr_cycle", 32'(in_ready), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic push_wr(input logic [9:0] a, input logic [8:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_pct > 0) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL send_timeout: got in_ready=0 for byte %0h expected in_ready=1", b);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(wr_data),   32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
    check({tag, "_word_cnt"},  32'(word_cnt),  32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    exp_q.delete();
    reset = 1'b1;
    check("rst_release_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_ready_after_edge", 32'(in_ready), 32'd1);
  endtask

  task automatic finish_scn(input string tag, input logic done, input logic err, input int cnt);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_load_done"},   32'(load_done), 32'(done));
    check({tag, "_load_err"},    32'(load_err),  32'(err));
    check({tag, "_core_hold"},   32'(core_hold), 32'(!done));
    check({tag, "_word_cnt"},    32'(word_cnt),  32'(cnt));
    if (done || err) check({tag, "_ready_terminal"}, 32'(in_ready), 32'd0);
  endtask

  task automatic image3();
    push_wr(10'd0, 9'h115);
    push_wr(10'd1, 9'h02A);
    push_wr(10'd2, 9'h1FF);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h15); send_byte(8'h01);
    send_byte(8'h2A); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h01);
    send_byte(8'hC0);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1: three-word image, valid held high
    do_reset();
    image3();
    finish_scn("s1", 1'b1, 1'b0, 3);

    // 2: empty image, good and bad checksum
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    finish_scn("s2a", 1'b1, 1'b0, 0);
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    finish_scn("s2b", 1'b0, 1'b1, 0);

    // 3: N=1025 exceeds capacity
    do_reset();
    send_byte(8'h01); send_byte(8'h04);
    check("s3_err_now",   32'(load_err), 32'd1);
    check("s3_ready_now", 32'(in_ready), 32'd0);
    finish_scn("s3", 1'b0, 1'b1, 0);

    // 4: second word has illegal high byte
    do_reset();
    push_wr(10'd0, 9'h105);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h01);
    send_byte(8'h07); send_byte(8'h02);
    finish_scn("s4", 1'b0, 1'b1, 1);

    // 5: reset between lo and hi of the sixth word, then a fresh image
    do_reset();
    send_byte(8'h08); send_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      push_wr(10'(i), {1'(i & 1), 8'(8'h10 + i)});
      send_byte(8'(8'h10 + i));
      send_byte(8'(i & 1));
    end
    send_byte(8'h15);
    check("s5_cnt_before_rst", 32'(word_cnt), 32'd5);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_reset_vals("s5_mid");
    check("s5_queue_empty_mid", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_wr(10'd0, 9'h034);
    push_wr(10'd1, 9'h156);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h00);
    send_byte(8'h56); send_byte(8'h01);
    send_byte(8'h63);
    finish_scn("s5", 1'b1, 1'b0, 2);

    // 6: scenario 1 with random idle gaps
    gap_pct = 30;
    do_reset();
    image3();
    finish_scn("s6", 1'b1, 1'b0, 3);
    gap_pct = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
